// File: rtl/scan_chain_master_if.sv
// Host-side register/command interface of scan_chain_master.
// The master modport drives it and the slave modport (the controller) answers.
interface scan_chain_master_if #(
    parameter int ADDR_W = 5
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_op;
    logic [7:0]        cmd_cycles;
    logic              done;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, cmd_valid, cmd_op, cmd_cycles,
        input  rd_data, cmd_ready, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr, cmd_valid, cmd_op, cmd_cycles,
        output rd_data, cmd_ready, done
    );
endinterface

// File: rtl/scan_chain_master.sv
// Scan chain master: swaps a host-written chain image with the core's scan chain
// and optionally runs the core for N cycles (RUN op built only with SCAN_MASTER_RUN_EN).
module scan_chain_master #(
    parameter int CHAIN_LEN = 168,
    parameter int ADDR_W    = 5
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    scan_chain_master_if.slave   host,
    output logic                 scan_enable_n_out,
    output logic                 proc_en_n_out,
    output logic                 scan_in_out,
    input  logic                 scan_out_in
);

    localparam int NBYTES = (CHAIN_LEN + 7) / 8;
    localparam int PAD_W  = NBYTES * 8;
`ifdef SCAN_MASTER_RUN_EN
    localparam int CNT_W  = ($clog2(CHAIN_LEN) > 8) ? $clog2(CHAIN_LEN) : 8;
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_RUN} state_t;
`else
    localparam int CNT_W  = $clog2(CHAIN_LEN);
    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;
`endif

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CHAIN_LEN-1:0] image_q, image_d;
    logic                 done_q, done_d;
    logic [PAD_W-1:0]     wr_image;
    logic [PAD_W-1:0]     rd_image;

`ifndef SCAN_MASTER_RUN_EN
    logic unused_cycles;
    assign unused_cycles = ^host.cmd_cycles;
`endif

    // NOTE: every signal written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        image_d  = image_q;
        done_d   = 1'b0;
        wr_image = PAD_W'(image_q);

        case (state_q)
            ST_IDLE: begin
                // The write is merged before a same-cycle SWAP starts, so the new byte shifts out.
                if (host.wr_en) begin
                    for (int i = 0; i < NBYTES; i++) begin
                        if (host.wr_addr == ADDR_W'(i)) wr_image[8*i +: 8] = host.wr_data;
                    end
                end
                image_d = wr_image[CHAIN_LEN-1:0];
                if (host.cmd_valid) begin
                    if (!host.cmd_op) begin
                        state_d = ST_SHIFT;
                        cnt_d   = CNT_W'(CHAIN_LEN - 1);
                    end else begin
`ifdef SCAN_MASTER_RUN_EN
                        if (host.cmd_cycles != 8'd0) begin
                            state_d = ST_RUN;
                            cnt_d   = CNT_W'(host.cmd_cycles - 8'd1);
                        end else begin
                            done_d  = 1'b1;
                        end
`else
                        done_d = 1'b1;
`endif
                    end
                end
            end
            ST_SHIFT: begin
                image_d = {image_q[CHAIN_LEN-2:0], scan_out_in};
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end
            end
`ifdef SCAN_MASTER_RUN_EN
            ST_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, matching the core that shares this clock.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            // NOTE: the image is a flop array rather than a RAM, so it can and
            // must be cleared by reset (no stale chain contents after an abort).
            image_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            image_q <= image_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        rd_image     = PAD_W'(image_q);
        host.rd_data = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            if (host.rd_addr == ADDR_W'(i)) host.rd_data = rd_image[8*i +: 8];
        end
    end

    assign host.cmd_ready    = (state_q == ST_IDLE);
    assign host.done         = done_q;
    assign scan_enable_n_out = (state_q != ST_SHIFT);
`ifdef SCAN_MASTER_RUN_EN
    assign proc_en_n_out     = (state_q != ST_RUN);
`else
    assign proc_en_n_out     = 1'b1;
`endif
    assign scan_in_out       = image_q[CHAIN_LEN-1];

endmodule
